// File: rtl/mmio_ep_pkg.sv
// mmio_ep_pkg: shared definitions for the MMIO port endpoint.
//   - opcode_e      : command opcodes carried on the odd (high) word of a pair write
//   - ST_*          : bit positions inside the status read word
//   - STATUS_CNT_W  : width of the FIFO count fields in the status word
package mmio_ep_pkg;

  localparam int STATUS_CNT_W = 4;

  typedef enum logic [15:0] {
    OP_NOP      = 16'h0000,
    OP_TX_PUSH  = 16'h0001,
    OP_RX_POP   = 16'h0002,
    OP_FLUSH    = 16'h0003,
    OP_IRQ_MASK = 16'h0004
  } opcode_e;

  localparam int ST_RX_NONEMPTY = 15;
  localparam int ST_TX_FULL     = 14;
  localparam int ST_RX_UNF      = 13;
  localparam int ST_TX_OVF      = 12;
  localparam int ST_RX_CNT_LSB  = 4;
  localparam int ST_TX_CNT_LSB  = 0;

endpackage

// File: rtl/ep_sync_fifo.sv
// ep_sync_fifo: single-clock first-word-fall-through FIFO.
//   clk, rst_n   : clock, asynchronous active-low reset (control state only)
//   push, wdata  : write request and data; ignored when full unless popped this cycle
//   pop          : read request; ignored when empty
//   flush        : empties the FIFO; outranks push and pop in the same cycle
//   head         : current head word (valid while !empty)
//   count        : number of stored entries
//   full, empty  : occupancy flags
// Pointers wrap modulo DEPTH and occupancy is a separate counter, so DEPTH
// need not be a power of two.
module ep_sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  // A push into a full FIFO is legal only when the head leaves the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; only the pointers/count define validity.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/mmio_port_endpoint.sv
// mmio_port_endpoint: peripheral side of one MMIO port pair.
// A rising edge of port_wr issues one command {port_lo = payload, port_hi = opcode}.
// Outbound payloads queue in a TX FIFO drained by the device (tx_*), inbound
// device words queue in an RX FIFO (rx_*) and are read back through rd_lo;
// rd_hi is a combinational status word.
// Optional build macro MMIO_EP_IRQ_EN adds the irq output, an irq_en register
// and the IRQ_MASK opcode.
// Ports:
//   clk, rst_n         : clock, asynchronous active-low reset
//   port_wr, port_rd   : write strobe (level), read strobe (unused here)
//   port_lo, port_hi   : payload word, opcode word
//   rd_lo, rd_hi       : RX head data, status word
//   tx_data/valid/ready: TX stream to device
//   rx_data/valid/ready: RX stream from device
//   irq                : (MMIO_EP_IRQ_EN only) rx_nonempty qualified by irq_en
module mmio_port_endpoint
  import mmio_ep_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             port_wr,
  input  logic             port_rd,
  input  logic [WIDTH-1:0] port_lo,
  input  logic [WIDTH-1:0] port_hi,
  output logic [WIDTH-1:0] rd_lo,
  output logic [WIDTH-1:0] rd_hi,
  output logic [WIDTH-1:0] tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  input  logic [WIDTH-1:0] rx_data,
  input  logic             rx_valid,
`ifdef MMIO_EP_IRQ_EN
  output logic             rx_ready,
  output logic             irq
`else
  output logic             rx_ready
`endif
);

  logic                    port_wr_q;
  logic                    cmd_fire;
  logic                    cmd_push;
  logic                    cmd_pop;
  logic                    cmd_flush;
  logic                    cmd_mask;
  logic                    tx_drain;
  logic                    rx_fill;
  logic                    tx_ovf;
  logic                    rx_unf;
  logic [WIDTH-1:0]        rx_head;
  logic [STATUS_CNT_W-1:0] tx_count;
  logic [STATUS_CNT_W-1:0] rx_count;
  logic                    tx_full;
  logic                    tx_empty;
  logic                    rx_full;
  logic                    rx_empty;
  logic                    rd_unused;

  // Read strobes carry no side effects in this build.
  assign rd_unused = port_rd;

  assign cmd_fire = port_wr && !port_wr_q;

  always_comb begin
    cmd_push  = 1'b0;
    cmd_pop   = 1'b0;
    cmd_flush = 1'b0;
    cmd_mask  = 1'b0;
    if (cmd_fire) begin
      case (port_hi)
        OP_TX_PUSH:  cmd_push  = 1'b1;
        OP_RX_POP:   cmd_pop   = 1'b1;
        OP_FLUSH:    cmd_flush = 1'b1;
        OP_IRQ_MASK: cmd_mask  = 1'b1;
        default:     ;
      endcase
    end
  end

  assign tx_valid = !tx_empty;
  assign rx_ready = !rx_full;
  assign tx_drain = tx_valid && tx_ready;
  assign rx_fill  = rx_valid && rx_ready;

  ep_sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(STATUS_CNT_W)) u_tx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (cmd_push),
    .pop   (tx_drain),
    .flush (cmd_flush),
    .wdata (port_lo),
    .head  (tx_data),
    .count (tx_count),
    .full  (tx_full),
    .empty (tx_empty)
  );

  ep_sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(STATUS_CNT_W)) u_rx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (rx_fill),
    .pop   (cmd_pop),
    .flush (cmd_flush),
    .wdata (rx_data),
    .head  (rx_head),
    .count (rx_count),
    .full  (rx_full),
    .empty (rx_empty)
  );

  // Command edge detect and sticky error flags. A TX_PUSH into a full FIFO is
  // only an overflow when no drain frees a slot in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      port_wr_q <= 1'b0;
      tx_ovf    <= 1'b0;
      rx_unf    <= 1'b0;
    end else begin
      port_wr_q <= port_wr;
      if (cmd_flush) begin
        tx_ovf <= 1'b0;
        rx_unf <= 1'b0;
      end else begin
        if (cmd_push && tx_full && !tx_drain) tx_ovf <= 1'b1;
        if (cmd_pop && rx_empty)              rx_unf <= 1'b1;
      end
    end
  end

  assign rd_lo = rx_empty ? '0 : rx_head;

  always_comb begin
    rd_hi = '0;
    rd_hi[ST_RX_NONEMPTY] = !rx_empty;
    rd_hi[ST_TX_FULL]     = tx_full;
    rd_hi[ST_RX_UNF]      = rx_unf;
    rd_hi[ST_TX_OVF]      = tx_ovf;
    rd_hi[ST_RX_CNT_LSB +: STATUS_CNT_W] = rx_count;
    rd_hi[ST_TX_CNT_LSB +: STATUS_CNT_W] = tx_count;
  end

`ifdef MMIO_EP_IRQ_EN
  logic irq_en;

  // irq follows the registered FIFO state, so it trails it by one clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_en <= 1'b0;
      irq    <= 1'b0;
    end else begin
      if (cmd_mask) irq_en <= port_lo[0];
      irq <= irq_en && !rx_empty;
    end
  end
`else
  logic mask_unused;
  assign mask_unused = cmd_mask;
`endif

endmodule
